hash_des_sbox_stream: RTL



---
 rtl/hash_des_sbox_stream_if.sv | 28 ++
 rtl/hash_des_sbox_stream.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hash_des_sbox_stream_if.sv
// Byte-stream / digest handshake bundle for hash_des_sbox_stream.
// The master is the byte source plus digest consumer; the slave is the hash core.
interface hash_des_sbox_stream_if #(
    parameter int N_NIB = 8,
    parameter int LEN_W = 64
);
    logic                 msg_valid;
    logic                 msg_ready;
    logic [7:0]           msg_byte;
    logic                 msg_last;
    logic                 empty_req;
    logic [4*N_NIB-1:0]   digest_out;
    logic                 digest_valid;
    logic                 digest_ready;
    logic                 busy;
    logic [LEN_W-1:0]     byte_count;
    logic [1:0]           fsm_state;

    modport master (
        output msg_valid, msg_byte, msg_last, empty_req, digest_ready,
        input  msg_ready, digest_out, digest_valid, busy, byte_count, fsm_state
    );

    modport slave (
        input  msg_valid, msg_byte, msg_last, empty_req, digest_ready,
        output msg_ready, digest_out, digest_valid, busy, byte_count, fsm_state
    );
endinterface

// File: rtl/hash_des_sbox_stream.sv
// Streaming DES-S5 nibble hash: absorbs one byte per cycle, digest via held valid/ready.
// Optional macro HASH_STREAM_ABORT_EN adds an 'abort' input that returns the core to IDLE.
module hash_des_sbox_stream #(
    parameter int                 N_NIB    = 8,
    parameter int                 ROUNDS   = 4,
    parameter int                 LEN_W    = 64,
    parameter logic [4*N_NIB-1:0] INIT_VAL = 32'h4B71DF03
) (
    input logic clk,
    input logic rst,
`ifdef HASH_STREAM_ABORT_EN
    input logic abort,
`endif
    hash_des_sbox_stream_if.slave bus
);
    localparam int W         = 4 * N_NIB;
    localparam int LEN_BYTES = LEN_W / 8;

    // DES S5, rows 0..3 concatenated; column 0 of each row sits in the top nibble.
    localparam logic [255:0] S5_LUT = {
        64'h2C41_7AB6_853F_D0E9,
        64'hEB2C_47D1_50FA_3986,
        64'h421B_AD78_F9C5_630E,
        64'hB8C7_1E2D_6F09_A453
    };

    typedef enum logic [1:0] {IDLE = 2'd0, ABSORB = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;

    state_t           state, state_n;
    logic [W-1:0]     h, h_n;
    logic [W-1:0]     dig, dig_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             dv, dv_n;
    logic             kill;
    logic             xfer;

    function automatic logic [3:0] sbox(input logic [5:0] x);
        logic [5:0] idx;
        idx = {x[5], x[0], x[4:1]};
        return S5_LUT[255 - 4 * int'(idx) -: 4];
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] x, input int n);
        logic [7:0] d;
        d = {x, x} << n;
        return d[7:4];
    endfunction

    function automatic logic [W-1:0] absorb(input logic [W-1:0] hv, input logic [7:0] m);
        logic [3:0]   s;
        logic [W-1:0] r;
        logic [W-1:0] t;
        s = sbox({m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]});
        r = hv;
        t = '0;
        for (int k = 0; k < ROUNDS; k++) begin
            for (int i = 0; i < N_NIB; i++)
                t[4*i +: 4] = rotl4(r[4*((i+1) % N_NIB) +: 4] ^ s, (i / 2) % 4);
            r = t;
        end
        return r;
    endfunction

    // Each output nibble mixes in one byte of the length, cycling through the counter bytes.
    function automatic logic [W-1:0] finalize(input logic [W-1:0] hv, input logic [LEN_W-1:0] c);
        logic [W-1:0] d;
        logic [7:0]   b;
        logic [3:0]   s;
        d = '0;
        for (int i = 0; i < N_NIB; i++) begin
            b = c[8*(i % LEN_BYTES) +: 8];
            s = sbox({b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]});
            d[4*i +: 4] = rotl4(hv[4*((i+1) % N_NIB) +: 4] ^ s, (i / 2) % 4);
        end
        return d;
    endfunction

`ifdef HASH_STREAM_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    // Valid/ready: a byte moves on a rising edge where msg_valid && msg_ready; the digest is
    // held with digest_valid until a rising edge sees digest_ready. Neither side may retract.
    assign bus.msg_ready    = !kill && ((state == IDLE && !bus.empty_req) || state == ABSORB);
    assign xfer             = bus.msg_valid && bus.msg_ready;
    assign bus.digest_out   = dig;
    assign bus.digest_valid = dv;
    assign bus.busy         = (state != IDLE);
    assign bus.byte_count   = cnt;
    assign bus.fsm_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h     <= INIT_VAL;
            cnt   <= '0;
            dig   <= '0;
            dv    <= 1'b0;
        end else begin
            state <= state_n;
            h     <= h_n;
            cnt   <= cnt_n;
            dig   <= dig_n;
            dv    <= dv_n;
        end
    end

    always_comb begin
        state_n = state;
        h_n     = h;
        cnt_n   = cnt;
        dig_n   = dig;
        dv_n    = dv;
        case (state)
            IDLE: begin
                if (bus.empty_req) begin
                    h_n     = INIT_VAL;
                    cnt_n   = '0;
                    state_n = FINAL;
                end else if (xfer) begin
                    h_n     = absorb(INIT_VAL, bus.msg_byte);
                    cnt_n   = LEN_W'(1);
                    state_n = bus.msg_last ? FINAL : ABSORB;
                end
            end
            ABSORB: begin
                if (xfer) begin
                    h_n   = absorb(h, bus.msg_byte);
                    cnt_n = cnt + LEN_W'(1);
                    if (bus.msg_last) state_n = FINAL;
                end
            end
            FINAL: begin
                dig_n   = finalize(h, cnt);
                dv_n    = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                if (bus.digest_ready) begin
                    dv_n    = 1'b0;
                    h_n     = INIT_VAL;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
            h_n     = INIT_VAL;
            cnt_n   = '0;
            dv_n    = 1'b0;
        end
    end
endmodule
